// File: rtl/cv_ctrl_pkg.sv
// Shared constants for the ColecoVision controller emulation: keypad pin codes,
// PS/2 scancodes and MiSTer joystick bit positions.
package cv_ctrl_pkg;

  localparam logic [3:0] KP_CODE_0      = 4'b0011;
  localparam logic [3:0] KP_CODE_1      = 4'b1110;
  localparam logic [3:0] KP_CODE_2      = 4'b1101;
  localparam logic [3:0] KP_CODE_3      = 4'b0110;
  localparam logic [3:0] KP_CODE_4      = 4'b0001;
  localparam logic [3:0] KP_CODE_5      = 4'b1001;
  localparam logic [3:0] KP_CODE_6      = 4'b0111;
  localparam logic [3:0] KP_CODE_7      = 4'b1100;
  localparam logic [3:0] KP_CODE_8      = 4'b1000;
  localparam logic [3:0] KP_CODE_9      = 4'b1011;
  localparam logic [3:0] KP_CODE_STAR   = 4'b1010;
  localparam logic [3:0] KP_CODE_HASH   = 4'b0101;
  localparam logic [3:0] KP_CODE_PURPLE = 4'b0100;
  localparam logic [3:0] KP_CODE_BLUE   = 4'b0010;
  localparam logic [3:0] KP_CODE_NONE   = 4'b1111;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] SC_MAIN_0 = 8'h45;
  localparam logic [7:0] SC_MAIN_1 = 8'h16;
  localparam logic [7:0] SC_MAIN_2 = 8'h1E;
  localparam logic [7:0] SC_MAIN_3 = 8'h26;
  localparam logic [7:0] SC_MAIN_4 = 8'h25;
  localparam logic [7:0] SC_MAIN_5 = 8'h2E;
  localparam logic [7:0] SC_MAIN_6 = 8'h36;
  localparam logic [7:0] SC_MAIN_7 = 8'h3D;
  localparam logic [7:0] SC_MAIN_8 = 8'h3E;
  localparam logic [7:0] SC_MAIN_9 = 8'h46;

  localparam logic [7:0] SC_NUM_0    = 8'h70;
  localparam logic [7:0] SC_NUM_1    = 8'h69;
  localparam logic [7:0] SC_NUM_2    = 8'h72;
  localparam logic [7:0] SC_NUM_3    = 8'h7A;
  localparam logic [7:0] SC_NUM_4    = 8'h6B;
  localparam logic [7:0] SC_NUM_5    = 8'h73;
  localparam logic [7:0] SC_NUM_6    = 8'h74;
  localparam logic [7:0] SC_NUM_7    = 8'h6C;
  localparam logic [7:0] SC_NUM_8    = 8'h75;
  localparam logic [7:0] SC_NUM_9    = 8'h7D;
  localparam logic [7:0] SC_NUM_STAR = 8'h7C;
  localparam logic [7:0] SC_NUM_HASH = 8'h4A;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE1  = 4;
  localparam int JOY_FIRE2  = 5;
  localparam int JOY_STAR   = 6;
  localparam int JOY_HASH   = 7;
  localparam int JOY_DIGIT0 = 8;
  localparam int JOY_PURPLE = 18;
  localparam int JOY_BLUE   = 19;

  // Key ids 0-9 are digits, 10 is *, 11 is #; KEY_NONE marks an unmapped code.
  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_MSB  = 4'd11;

  function automatic logic [3:0] mainRowDigit(input logic [7:0] code);
    case (code)
      SC_MAIN_0: return 4'd0;
      SC_MAIN_1: return 4'd1;
      SC_MAIN_2: return 4'd2;
      SC_MAIN_3: return 4'd3;
      SC_MAIN_4: return 4'd4;
      SC_MAIN_5: return 4'd5;
      SC_MAIN_6: return 4'd6;
      SC_MAIN_7: return 4'd7;
      SC_MAIN_8: return 4'd8;
      SC_MAIN_9: return 4'd9;
      default:   return KEY_NONE;
    endcase
  endfunction

  function automatic logic [3:0] numpadKey(input logic [7:0] code);
    case (code)
      SC_NUM_0:    return 4'd0;
      SC_NUM_1:    return 4'd1;
      SC_NUM_2:    return 4'd2;
      SC_NUM_3:    return 4'd3;
      SC_NUM_4:    return 4'd4;
      SC_NUM_5:    return 4'd5;
      SC_NUM_6:    return 4'd6;
      SC_NUM_7:    return 4'd7;
      SC_NUM_8:    return 4'd8;
      SC_NUM_9:    return 4'd9;
      SC_NUM_STAR: return 4'd10;
      SC_NUM_HASH: return 4'd11;
      default:     return KEY_NONE;
    endcase
  endfunction

  // Reorders joystick keypad bits into priority order {0..9,*,#,Purple,Blue}, MSB first.
  function automatic logic [13:0] padFromJoy(input logic [19:0] j);
    return {j[JOY_DIGIT0+0], j[JOY_DIGIT0+1], j[JOY_DIGIT0+2], j[JOY_DIGIT0+3],
            j[JOY_DIGIT0+4], j[JOY_DIGIT0+5], j[JOY_DIGIT0+6], j[JOY_DIGIT0+7],
            j[JOY_DIGIT0+8], j[JOY_DIGIT0+9], j[JOY_STAR], j[JOY_HASH],
            j[JOY_PURPLE], j[JOY_BLUE]};
  endfunction

endpackage

// File: rtl/cv_kp_encode.sv
// Priority encoder from the 14-key keypad vector (MSB = key 0) to the
// active-low keypad pin code the console expects.
module cv_kp_encode
  import cv_ctrl_pkg::*;
(
  input  logic [13:0] vec_i,
  output logic [3:0]  code_o
);

  always_comb begin
    code_o = KP_CODE_NONE;
    if      (vec_i[13]) code_o = KP_CODE_0;
    else if (vec_i[12]) code_o = KP_CODE_1;
    else if (vec_i[11]) code_o = KP_CODE_2;
    else if (vec_i[10]) code_o = KP_CODE_3;
    else if (vec_i[9])  code_o = KP_CODE_4;
    else if (vec_i[8])  code_o = KP_CODE_5;
    else if (vec_i[7])  code_o = KP_CODE_6;
    else if (vec_i[6])  code_o = KP_CODE_7;
    else if (vec_i[5])  code_o = KP_CODE_8;
    else if (vec_i[4])  code_o = KP_CODE_9;
    else if (vec_i[3])  code_o = KP_CODE_STAR;
    else if (vec_i[2])  code_o = KP_CODE_HASH;
    else if (vec_i[1])  code_o = KP_CODE_PURPLE;
    else if (vec_i[0])  code_o = KP_CODE_BLUE;
  end

endmodule

// File: rtl/cv_keypad_ctrl.sv
// Two-port ColecoVision controller emulation: MiSTer joysticks plus a PS/2
// keyboard mapped onto one port's keypad, with registered active-low pins.
module cv_keypad_ctrl
  import cv_ctrl_pkg::*;
#(
  parameter int KBD_PORT = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [10:0] ps2_key_i,
  input  logic [31:0] joy0_i,
  input  logic [31:0] joy1_i,
  input  logic        swap_i,
  input  logic [1:0]  ctrl_p5_i,
  input  logic [1:0]  ctrl_p8_i,
  output logic [1:0]  ctrl_p1_o,
  output logic [1:0]  ctrl_p2_o,
  output logic [1:0]  ctrl_p3_o,
  output logic [1:0]  ctrl_p4_o,
  output logic [1:0]  ctrl_p6_o
);

  logic [11:0] keys_q, keys_d;
  logic        shift_q, shift_d;
  logic        armed_q, armed_d;
  logic        strobePrev_q, strobePrev_d;
  logic [3:0]  mainDigit, numKey;
  logic [7:0]  scanCode;
  logic        press;

  logic [1:0][3:0] nib_q, nib_d;
  logic [1:0]      p6_q, p6_d;

  assign scanCode  = ps2_key_i[7:0];
  assign press     = ps2_key_i[9];
  assign mainDigit = mainRowDigit(scanCode);
  assign numKey    = numpadKey(scanCode);

  // The first clock after reset only samples the strobe so a level held through
  // reset is never mistaken for a fresh event.
  always_comb begin
    keys_d       = keys_q;
    shift_d      = shift_q;
    armed_d      = 1'b1;
    strobePrev_d = ps2_key_i[10];
    if (armed_q && (ps2_key_i[10] != strobePrev_q)) begin
      if (scanCode == SC_LSHIFT || scanCode == SC_RSHIFT) begin
        shift_d = press;
      end else if (mainDigit != KEY_NONE) begin
        keys_d[KEY_MSB - mainDigit] = press & ~shift_q;
        if (mainDigit == 4'd8) keys_d[1] = press & shift_q;
        if (mainDigit == 4'd3) keys_d[0] = press & shift_q;
      end else if (numKey != KEY_NONE) begin
        keys_d[KEY_MSB - numKey] = press;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      keys_q       <= '0;
      shift_q      <= 1'b0;
      armed_q      <= 1'b0;
      strobePrev_q <= 1'b0;
    end else begin
      keys_q       <= keys_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      strobePrev_q <= strobePrev_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : gPort
    logic [19:0] portJoy;
    logic [13:0] basePad, padVec;
    logic [3:0]  kpCode, kpNib, joyNib;

    assign portJoy = ((p == 1) ^ swap_i) ? joy1_i[19:0] : joy0_i[19:0];
    assign basePad = padFromJoy(portJoy);

    if (p == KBD_PORT) begin : gKbd
      assign padVec = basePad | {keys_q, 2'b00};
    end else begin : gNoKbd
      assign padVec = basePad;
    end

    cv_kp_encode uEncode (
      .vec_i  (padVec),
      .code_o (kpCode)
    );

    assign kpNib  = ctrl_p5_i[p] ? 4'hF : kpCode;
    assign joyNib = ctrl_p8_i[p] ? 4'hF :
                    ~{portJoy[JOY_U], portJoy[JOY_D], portJoy[JOY_L], portJoy[JOY_R]};
    assign nib_d[p] = kpNib & joyNib;
    assign p6_d[p]  = (~portJoy[JOY_FIRE2] | ctrl_p5_i[p]) &
                      (~portJoy[JOY_FIRE1] | ctrl_p8_i[p]);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      nib_q <= '1;
      p6_q  <= '1;
    end else begin
      nib_q <= nib_d;
      p6_q  <= p6_d;
    end
  end

  assign ctrl_p1_o = {nib_q[1][3], nib_q[0][3]};
  assign ctrl_p2_o = {nib_q[1][2], nib_q[0][2]};
  assign ctrl_p3_o = {nib_q[1][1], nib_q[0][1]};
  assign ctrl_p4_o = {nib_q[1][0], nib_q[0][0]};
  assign ctrl_p6_o = p6_q;

endmodule

// File: tb/tb_cv_keypad_ctrl.sv
// Randomised bench for cv_keypad_ctrl: a key-table model predicts every pin each
// cycle, and a directed prologue pins that model with hand-computed codes.
module tb_cv_keypad_ctrl;

  localparam int KBD = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2 = '0;
  logic [31:0] joy0 = '0, joy1 = '0;
  logic        swap = 1'b0;
  logic [1:0]  p5 = 2'b11, p8 = 2'b11;
  logic [1:0]  p1o, p2o, p3o, p4o, p6o;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  cv_keypad_ctrl #(.KBD_PORT(KBD)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .ps2_key_i (ps2),
    .joy0_i    (joy0),
    .joy1_i    (joy1),
    .swap_i    (swap),
    .ctrl_p5_i (p5),
    .ctrl_p8_i (p8),
    .ctrl_p1_o (p1o),
    .ctrl_p2_o (p2o),
    .ctrl_p3_o (p3o),
    .ctrl_p4_o (p4o),
    .ctrl_p6_o (p6o)
  );

  always #5 clk = ~clk;

  // Key ids: 0-9 digits, 10 = *, 11 = #, 12 = Purple, 13 = Blue (also priority order).
  logic [7:0] mainTbl [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] numTbl  [12] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D, 8'h7C, 8'h4A};
  logic [3:0] codeTbl [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001, 4'b1001, 4'b0111,
                               4'b1100, 4'b1000, 4'b1011, 4'b1010, 4'b0101, 4'b0100, 4'b0010};

  bit mKey [12] = '{default: 1'b0};
  bit mShift = 1'b0, mArmed = 1'b0, mPrev = 1'b0;
  logic [1:0] eP1 = 2'b11, eP2 = 2'b11, eP3 = 2'b11, eP4 = 2'b11, eP6 = 2'b11;

  bit pressed [14];
  logic [31:0] mJoy;
  logic [3:0]  mKp, mJs, mNib;

  task automatic computeExpected();
    for (int n = 0; n < 2; n++) begin
      mJoy = (((n == 1) ? 1'b1 : 1'b0) ^ swap) ? joy1 : joy0;
      for (int k = 0; k < 14; k++) pressed[k] = 1'b0;
      for (int d = 0; d < 10; d++) pressed[d] = mJoy[8 + d];
      pressed[10] = mJoy[6];
      pressed[11] = mJoy[7];
      pressed[12] = mJoy[18];
      pressed[13] = mJoy[19];
      if (n == KBD) for (int k = 0; k < 12; k++) pressed[k] = pressed[k] | mKey[k];
      mKp = 4'hF;
      if (!p5[n]) begin
        for (int k = 0; k < 14; k++) begin
          if (pressed[k]) begin
            mKp = codeTbl[k];
            break;
          end
        end
      end
      mJs  = p8[n] ? 4'hF : {~mJoy[3], ~mJoy[2], ~mJoy[1], ~mJoy[0]};
      mNib = mKp & mJs;
      eP1[n] = mNib[3];
      eP2[n] = mNib[2];
      eP3[n] = mNib[1];
      eP4[n] = mNib[0];
      eP6[n] = (!mJoy[5] || p5[n]) && (!mJoy[4] || p8[n]);
    end
  endtask

  task automatic applyPs2Model();
    logic [7:0] code;
    bit pr;
    if (!mArmed) begin
      mArmed = 1'b1;
      mPrev  = ps2[10];
    end else if (ps2[10] != mPrev) begin
      mPrev = ps2[10];
      code  = ps2[7:0];
      pr    = ps2[9];
      if (code == 8'h12 || code == 8'h59) begin
        mShift = pr;
      end else begin
        for (int d = 0; d < 10; d++) begin
          if (code == mainTbl[d]) begin
            mKey[d] = pr && !mShift;
            if (d == 8) mKey[10] = pr && mShift;
            if (d == 3) mKey[11] = pr && mShift;
          end
        end
        for (int k = 0; k < 12; k++) if (code == numTbl[k]) mKey[k] = pr;
      end
    end
  endtask

  // Pins seen after an edge come from inputs and key state as they were before it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 12; k++) mKey[k] = 1'b0;
      mShift = 1'b0;
      mArmed = 1'b0;
      mPrev  = 1'b0;
      eP1 = 2'b11; eP2 = 2'b11; eP3 = 2'b11; eP4 = 2'b11; eP6 = 2'b11;
    end else begin
      computeExpected();
      applyPs2Model();
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checks++;
      if ({p1o, p2o, p3o, p4o, p6o} !== {eP1, eP2, eP3, eP4, eP6}) begin
        errors++;
        $display("[TB] FAIL modelCompare t=%0t got p1..p6=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                 $time, p1o, p2o, p3o, p4o, p6o, eP1, eP2, eP3, eP4, eP6);
      end
    end
  end

  function automatic logic [3:0] portNib(input int n);
    return {p1o[n], p2o[n], p3o[n], p4o[n]};
  endfunction

  task automatic applyStimulus(input bit press, input logic [7:0] code);
    ps2 = {~ps2[10], press, 1'b0, code};
  endtask

  task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] rndCode;

  initial begin
    waitCycles(3);
    checkEn = 1'b1;
    checkOutput("resetAllOnes", {p1o, p2o, p3o, p4o, p6o}, 10'h3FF);

    // Strobe high through reset release must not count as an event.
    ps2[10] = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    waitCycles(3);
    p5 = 2'b00;
    waitCycles(1);
    checkOutput("noEventAfterRelease", {6'd0, portNib(0)}, 10'h00F);
    checkOutput("noEventPort1", {6'd0, portNib(1)}, 10'h00F);

    // Unshifted 0x3E is key 8, visible two clocks after the toggle.
    p5 = 2'b10;
    applyStimulus(1'b1, 8'h3E);
    waitCycles(1);
    checkOutput("key8NotYet", {6'd0, portNib(0)}, 10'h00F);
    waitCycles(1);
    checkOutput("key8Port0", {6'd0, portNib(0)}, 10'h008);
    checkOutput("key8Port1", {6'd0, portNib(1)}, 10'h00F);
    applyStimulus(1'b0, 8'h3E);
    waitCycles(2);
    checkOutput("key8Released", {6'd0, portNib(0)}, 10'h00F);

    // Shifted 0x26 is # rather than 3.
    applyStimulus(1'b1, 8'h12);
    waitCycles(1);
    applyStimulus(1'b1, 8'h26);
    waitCycles(2);
    checkOutput("shiftHash", {6'd0, portNib(0)}, 10'h005);
    applyStimulus(1'b0, 8'h26);
    waitCycles(2);
    checkOutput("hashReleased", {6'd0, portNib(0)}, 10'h00F);
    applyStimulus(1'b0, 8'h12);
    waitCycles(1);

    p5 = 2'b11; p8 = 2'b10; joy0 = 32'h0000_0009;
    waitCycles(1);
    checkOutput("joyRightUp", {6'd0, portNib(0)}, 10'h006);
    swap = 1'b1; p8 = 2'b00;
    waitCycles(1);
    checkOutput("swapPort1", {6'd0, portNib(1)}, 10'h006);
    checkOutput("swapPort0", {6'd0, portNib(0)}, 10'h00F);
    swap = 1'b0; p8 = 2'b11; joy0 = '0;

    joy1 = 32'h0000_0030; p5 = 2'b00; p8 = 2'b11;
    waitCycles(1);
    checkOutput("fire2Sel", {9'd0, p6o[1]}, 10'h000);
    p5 = 2'b11; p8 = 2'b00;
    waitCycles(1);
    checkOutput("fire1Sel", {9'd0, p6o[1]}, 10'h000);
    p8 = 2'b11;
    waitCycles(1);
    checkOutput("fireDeselected", {9'd0, p6o[1]}, 10'h001);
    joy1 = '0;

    // Numpad 1 outranks joystick 5; before the key lands only 5 is seen.
    applyStimulus(1'b1, 8'h69);
    joy0 = 32'h0000_2000; p5 = 2'b10;
    waitCycles(1);
    checkOutput("joyDigit5", {6'd0, portNib(0)}, 10'h009);
    waitCycles(1);
    checkOutput("priorityKey1", {6'd0, portNib(0)}, 10'h00E);
    @(posedge clk); #2 reset = 1'b1;
    #1 checkOutput("asyncReset", {p1o, p2o, p3o, p4o, p6o}, 10'h3FF);
    @(posedge clk); #2 reset = 1'b0;
    joy0 = '0;

    // An event that coincides with reset must be dropped.
    @(posedge clk); #2 reset = 1'b1;
    applyStimulus(1'b1, 8'h45);
    waitCycles(2);
    @(posedge clk); #2 reset = 1'b0;
    waitCycles(3);
    checkOutput("eventDiscarded", {6'd0, portNib(0)}, 10'h00F);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: rndCode = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59;
          1: rndCode = mainTbl[$urandom_range(0, 9)];
          2: rndCode = numTbl[$urandom_range(0, 11)];
          default: rndCode = 8'($urandom);
        endcase
        applyStimulus(1'($urandom_range(0, 1)), rndCode);
      end
      if ($urandom_range(0, 7) == 0) p5 = 2'($urandom);
      if ($urandom_range(0, 7) == 0) p8 = 2'($urandom);
      if ($urandom_range(0, 15) == 0) swap = 1'($urandom);
      if ($urandom_range(0, 7) == 0) joy0 = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 7) == 0) joy1 = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv_keypad_ctrl.md
CV_KEYPAD_CTRL -- requirements
Module: cv_keypad_ctrl

Interface
REQ-001 SHALL have parameter KBD_PORT, default 0, selecting which post-swap controller port receives the PS/2 keypad keys.
REQ-002 clk_i  in  1  system clock (clk_sys); all logic is in this single clock domain.
REQ-003 reset_i  in  1  reset; asynchronous, active-high.
REQ-004 ps2_key_i  in  11  PS/2 event: [10] toggle strobe, [9] 1 = press / 0 = release, [7:0] scancode; [8] ignored.
REQ-005 joy0_i, joy1_i  in  32 each  MiSTer joystick words: [0] R, [1] L, [2] D, [3] U, [4] Fire1, [5] Fire2, [6] *, [7] #, [17:8] digits 0-9, [18] Purple, [19] Blue; active-high.
REQ-006 swap_i  in  1  when 1, controller port 0 uses joy1_i and port 1 uses joy0_i.
REQ-007 ctrl_p5_i  in  2  per-port keypad-select strobe, active-low.
REQ-008 ctrl_p8_i  in  2  per-port joystick-select strobe, active-low.
REQ-009 ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o  out  2 each  per-port controller pins, active-low; index = port.

Function
REQ-010 SHALL detect a PS/2 event when ps2_key_i[10] differs from its registered previous value, and only when the armed flag is set.
REQ-011 SHALL set the armed flag on the first clock after reset release, and on that clock copy ps2_key_i[10] into the previous value without decoding an event.
REQ-012 SHALL keep a shift flag: scancodes 0x12 and 0x59 set it to ps2_key_i[9].
REQ-013 SHALL keep a 12-bit key state K = {0,1,2,3,4,5,6,7,8,9,*,#}, with MSB = key 0.
REQ-014 Main-row digit codes 0x45,16,1E,26,25,2E,36,3D,3E,46 (keys 0-9) SHALL set that digit bit to press AND NOT shift.
REQ-015 Code 0x3E SHALL also set * to press AND shift; code 0x26 SHALL also set # to press AND shift; both bit updates happen in the same cycle.
REQ-016 Numpad codes 0x70,69,72,7A,6B,73,74,6C,75,7D (keys 0-9), 0x7C (*) and 0x4A (#) SHALL set the mapped bit to press, ignoring shift.
REQ-017 Shift changes SHALL NOT alter bits that are already latched.
REQ-018 Unmapped scancodes SHALL change no state.
REQ-019 Per-port keypad vector SHALL be the joystick bits {0-9,*,#,Purple,Blue} of that port, ORed with K on port KBD_PORT only.
REQ-020 Keypad nibble (p1..p4) when ctrl_p5_i[n]=0 SHALL be the priority encoding of the first set bit in order 0,1,...,9,*,#,Purple,Blue. Codes: 0=0011, 1=1110, 2=1101, 3=0110, 4=0001, 5=1001, 6=0111, 7=1100, 8=1000, 9=1011, *=1010, #=0101, Purple=0100, Blue=0010, none=1111. When ctrl_p5_i[n]=1 the nibble SHALL be 1111.
REQ-021 Joystick nibble when ctrl_p8_i[n]=0 SHALL be ~{U,D,L,R}; when ctrl_p8_i[n]=1 it SHALL be 1111.
REQ-022 {p1,p2,p3,p4}[n] SHALL equal keypad nibble AND joystick nibble.
REQ-023 p6[n] SHALL equal (~Fire2 OR ctrl_p5_i[n]) AND (~Fire1 OR ctrl_p8_i[n]).
REQ-024 All outputs SHALL be registered.
REQ-025 Latency SHALL be 1 clock from a select, joystick or swap change, and 2 clocks from the PS/2 strobe toggle.
REQ-026 When both selects are low, both nibbles SHALL be ANDed; when both are high, outputs SHALL be all 1.
REQ-027 A PS/2 event and a select change in the same cycle SHALL both take effect with their own latencies.

Reset
REQ-028 While reset_i=1, SHALL hold K=0, shift=0, armed=0, previous strobe=0, and all outputs=1.
REQ-029 Reset asserted mid-event SHALL discard the event; no key SHALL appear latched after release.

Structure
REQ-030 Package cv_ctrl_pkg SHALL hold the 15 keypad code localparams, the scancode constants, and the joystick bit-index constants.
REQ-031 Combinational sub-module cv_kp_encode (14-bit vector in, 4-bit code out) SHALL be instantiated once per port.

Verification
REQ-032 Reset release with ps2_key_i[10]=1 held -> no event, K=0, outputs stay 1.
REQ-033 Toggle strobe with {press,0x3E}, shift=0, then ctrl_p5_i=2'b10 -> ctrl_p{1..4}_o[0] = 1000 two clocks after the toggle; port 1 = 1111.
REQ-034 Shift press (0x12), then 0x26 press -> # bit set, 3 bit clear, port-0 nibble 0101; releasing 0x26 -> 1111.
REQ-035 joy0_i[0]=1 and joy0_i[3]=1, ctrl_p8_i=2'b10 -> port-0 nibble {0,1,1,0}; with swap_i=1 -> port 1 shows it, port 0 = 1111.
REQ-036 joy1_i[5]=1 and joy1_i[4]=1; p5=0, p8=1 -> ctrl_p6_o[1]=0. Then p5=1, p8=0 -> 0. Then p5=1, p8=1 -> 1.
REQ-037 Numpad 1 and joystick digit 5 both active -> code 1110 (priority); reset pulsed -> all outputs 1 immediately.
